pipe_reg: RTL and testbench

- Parametrised, multi-stage register pipeline with valid/ready flow control on both sides.
- Generalises the single reset-able D flip-flop to WIDTH-bit data, STAGES depth, backpressure, bubble collapsing, synchronous flush and an occupancy count.
- Used as the standard retiming and buffering stage between producer and consumer blocks in the design.

---
 rtl/pipe_reg.sv | 77 +++++++
 tb/tb_pipe_reg.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg.sv
// Multi-stage valid/ready register pipeline with bubble collapsing, synchronous flush
// and a registered occupancy count.
module pipe_reg #(
  parameter int               WIDTH       = 8,
  parameter int               STAGES      = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [$clog2(STAGES+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(STAGES + 1);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] v_next;
  logic [STAGES-1:0] mv;
  logic [WIDTH-1:0]  d [STAGES];
  logic              space;
  logic              accept;

  function automatic logic [OCC_W-1:0] count_ones(input logic [STAGES-1:0] x);
    logic [OCC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < STAGES; i++) cnt = cnt + OCC_W'(x[i]);
    return cnt;
  endfunction

  // Walk from the output side: a stage can move when the one above is empty or moving.
  always_comb begin
    mv    = '0;
    space = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      mv[i] = v[i] & space;
      space = !v[i] | space;
    end
    in_ready = reset_n & !clear & space;
    accept   = in_valid & in_ready;
  end

  always_comb begin
    v_next = v;
    if (clear) begin
      v_next = '0;
    end else begin
      v_next[0] = accept | (v[0] & !mv[0]);
      for (int i = 1; i < STAGES; i++) v_next[i] = mv[i-1] | (v[i] & !mv[i]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v         <= '0;
      occupancy <= '0;
      for (int i = 0; i < STAGES; i++) d[i] <= RESET_VALUE;
    end else begin
      v         <= v_next;
      occupancy <= count_ones(v_next);
      if (accept) d[0] <= in_data;
      // Flush only drops valid bits; data registers keep their contents.
      for (int i = 1; i < STAGES; i++) begin
        if (!clear && mv[i-1]) d[i] <= d[i-1];
      end
    end
  end

  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];

endmodule

// File: tb/tb_pipe_reg.sv
// Directed bench for pipe_reg: a queue-of-words model checked every falling edge,
// plus hand-computed expectations for each scenario.
module tb_pipe_reg;

  localparam int         W  = 8;
  localparam int         S  = 3;
  localparam logic [7:0] RV = 8'h00;

  logic                        clock;
  logic                        reset_n;
  logic                        clear;
  logic                        in_valid;
  logic                        in_ready;
  logic [W-1:0]                in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [W-1:0]                out_data;
  logic [$clog2(S+1)-1:0]      occupancy;

  int vectors     = 0;
  int miscompares = 0;

  pipe_reg #(.WIDTH(W), .STAGES(S), .RESET_VALUE(RV)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Model: words in arrival order, each tagged with the stage position it occupies.
  typedef struct {
    logic [7:0] data;
    int         pos;
  } ent_t;

  ent_t       q[$];
  logic [7:0] last_out = RV;

  always @(negedge clock) begin
    bit         moved [S];
    int         np [S];
    int         prev_np;
    bit         ready_m;
    bit         eov;
    logic [7:0] eod;
    if (!reset_n) begin
      chk("m_rst_in_ready",  32'(in_ready),  32'h0);
      chk("m_rst_out_valid", 32'(out_valid), 32'h0);
      chk("m_rst_out_data",  32'(out_data),  32'(RV));
      chk("m_rst_occupancy", 32'(occupancy), 32'h0);
      q.delete();
      last_out = RV;
    end else begin
      prev_np = S + 1;
      for (int j = 0; j < q.size(); j++) begin
        if (q[j].pos == S - 1) moved[j] = out_ready;
        else                   moved[j] = (q[j].pos + 1 != prev_np);
        np[j]   = moved[j] ? q[j].pos + 1 : q[j].pos;
        prev_np = np[j];
      end
      if (clear)                         ready_m = 1'b0;
      else if (q.size() == 0)            ready_m = 1'b1;
      else if (q[q.size()-1].pos != 0)   ready_m = 1'b1;
      else                               ready_m = moved[q.size()-1];
      eov = (q.size() > 0) && (q[0].pos == S - 1);
      eod = eov ? q[0].data : last_out;
      chk("m_in_ready",  32'(in_ready),  32'(ready_m));
      chk("m_out_valid", 32'(out_valid), 32'(eov));
      chk("m_out_data",  32'(out_data),  32'(eod));
      chk("m_occupancy", 32'(occupancy), 32'(q.size()));
      if (clear) begin
        q.delete();
      end else begin
        for (int j = 0; j < q.size(); j++) begin
          if (moved[j] && np[j] == S - 1) last_out = q[j].data;
          q[j].pos = np[j];
        end
        if (q.size() > 0 && q[0].pos == S) void'(q.pop_front());
        if (in_valid && ready_m) begin
          q.push_back('{in_data, 0});
          if (S == 1) last_out = in_data;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;

    // Reset holds everything empty; release between edges, then A5 passes through.
    repeat (3) cyc();
    #1;
    chk("t1_rst_in_ready",  32'(in_ready),  32'h0);
    chk("t1_rst_out_valid", 32'(out_valid), 32'h0);
    chk("t1_rst_out_data",  32'(out_data),  32'h00);
    chk("t1_rst_occupancy", 32'(occupancy), 32'h0);
    reset_n = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc(); cyc();
    #1;
    chk("t1_out_valid", 32'(out_valid), 32'h1);
    chk("t1_out_data",  32'(out_data),  32'hA5);
    chk("t1_occupancy", 32'(occupancy), 32'h1);
    cyc(); #1;
    chk("t1_empty_valid", 32'(out_valid), 32'h0);
    chk("t1_empty_data",  32'(out_data),  32'hA5);

    // Streaming 1..8 with the consumer always ready.
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1; in_data = 8'(k);
      #1;
      chk("t2_in_ready", 32'(in_ready), 32'h1);
      if (k >= 4) begin
        chk("t2_out_valid", 32'(out_valid), 32'h1);
        chk("t2_out_data",  32'(out_data),  32'(k - 3));
        chk("t2_occupancy", 32'(occupancy), 32'h3);
      end
      cyc();
    end
    in_valid = 1'b0;
    #1;
    chk("t2_tail_data", 32'(out_data), 32'h06);
    repeat (3) cyc();
    #1;
    chk("t2_drained_occ",  32'(occupancy), 32'h0);
    chk("t2_drained_data", 32'(out_data),  32'h08);

    // Backpressure: three words fill the pipe, the fourth waits at the source.
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1; in_data = 8'(k);
      #1;
      chk("t3_fill_ready", 32'(in_ready), 32'h1);
      cyc();
    end
    in_data = 8'h04;
    #1;
    chk("t3_full_ready", 32'(in_ready),  32'h0);
    chk("t3_full_occ",   32'(occupancy), 32'h3);
    chk("t3_full_data",  32'(out_data),  32'h01);
    cyc(); cyc(); #1;
    chk("t3_hold_data",  32'(out_data),  32'h01);
    chk("t3_hold_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    #1;
    chk("t3_release_ready", 32'(in_ready), 32'h1);
    for (int j = 0; j < 4; j++) begin
      chk("t3_drain_valid", 32'(out_valid), 32'h1);
      chk("t3_drain_data",  32'(out_data),  32'(j + 1));
      cyc();
      in_valid = 1'b0;
      #1;
    end
    chk("t3_done_valid", 32'(out_valid), 32'h0);

    // Bubble collapse behind a stalled output.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h10; cyc();
    in_valid = 1'b0; cyc();
    in_valid = 1'b1; in_data = 8'h20; cyc();
    in_valid = 1'b0; cyc();
    #1;
    chk("t4_occ",      32'(occupancy), 32'h2);
    chk("t4_data",     32'(out_data),  32'h10);
    chk("t4_in_ready", 32'(in_ready),  32'h1);
    cyc(); #1;
    chk("t4_occ_hold", 32'(occupancy), 32'h2);
    out_ready = 1'b1;
    repeat (2) cyc();
    #1;
    chk("t4_drain_valid", 32'(out_valid), 32'h0);
    chk("t4_drain_data",  32'(out_data),  32'h20);

    // Full pipe: emit and accept on the same edge.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 8'(8'h31 + k); cyc();
    end
    in_data = 8'h55; out_ready = 1'b1;
    #1;
    chk("t5_in_ready", 32'(in_ready),  32'h1);
    chk("t5_occ_pre",  32'(occupancy), 32'h3);
    cyc();
    in_valid = 1'b0;
    #1;
    chk("t5_occ_post", 32'(occupancy), 32'h3);
    chk("t5_data0",    32'(out_data),  32'h32);
    cyc(); #1;
    chk("t5_data1",    32'(out_data),  32'h33);
    cyc(); #1;
    chk("t5_data2",    32'(out_data),  32'h55);
    chk("t5_valid2",   32'(out_valid), 32'h1);
    cyc(); #1;
    chk("t5_empty",    32'(out_valid), 32'h0);

    // Clear with two words inside, then asynchronous reset on a full pipe.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h61; cyc();
    in_data = 8'h62; cyc();
    in_valid = 1'b0;
    #1;
    chk("t6_occ_pre", 32'(occupancy), 32'h2);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h63;
    #1;
    chk("t6_clear_ready", 32'(in_ready), 32'h0);
    cyc();
    clear = 1'b0; in_valid = 1'b0;
    #1;
    chk("t6_clear_occ",   32'(occupancy), 32'h0);
    chk("t6_clear_valid", 32'(out_valid), 32'h0);
    chk("t6_clear_data",  32'(out_data),  32'h55);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 8'(8'h71 + k); cyc();
    end
    in_valid = 1'b0;
    #1;
    chk("t6_refill_occ",  32'(occupancy), 32'h3);
    chk("t6_refill_data", 32'(out_data),  32'h71);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'h0);
    chk("t6_rst_data",  32'(out_data),  32'(RV));
    chk("t6_rst_occ",   32'(occupancy), 32'h0);
    chk("t6_rst_ready", 32'(in_ready),  32'h0);
    cyc();
    reset_n = 1'b1;
    cyc(); #1;
    chk("t6_post_ready", 32'(in_ready),  32'h1);
    chk("t6_post_valid", 32'(out_valid), 32'h0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h81; cyc();
    in_valid = 1'b0;
    cyc(); cyc(); #1;
    chk("t6_post_data",  32'(out_data),  32'h81);
    chk("t6_post_vld",   32'(out_valid), 32'h1);

    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
